// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a per-register pending-write
// scoreboard for RAW hazard detection. Reads are asynchronous. Writes,
// counter updates and the sticky write-error flag change on the rising edge
// of clk.
// Optional build macro: REG_FILE_SB_BYPASS_EN adds write-through forwarding
// from the write port to the read ports.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_vld,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_rdy,
  input  logic                     flush,
  output logic                     pend_any,
  output logic                     wr_err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              wr_err_q;
  logic              wr_err_d;

  // A claim is accepted only while the target counter has headroom.
  assign claim_rdy = (cnt_q[claim_addr] != CNT_MAX);
  assign wr_err    = wr_err_q;

  // Storage next state: the write port lands regardless of flush or claims.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Pending counters: +1 on accepted claim, -1 on write to a non-zero
  // counter, net zero when both hit the same register, flush clears all.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (claim_vld && claim_rdy && (claim_addr == ADDR_W'(r)) &&
                   !(we && (wr_addr == ADDR_W'(r)) && (cnt_q[r] != '0))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (we && (wr_addr == ADDR_W'(r)) && (cnt_q[r] != '0) &&
                   !(claim_vld && claim_rdy && (claim_addr == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Sticky error: a write with nothing pending, unless flush is squashing state.
  always_comb begin
    wr_err_d = wr_err_q;
    if (we && !flush && (cnt_q[wr_addr] == '0)) begin
      wr_err_d = 1'b1;
    end
  end

  // Any outstanding write anywhere in the file.
  always_comb begin
    pend_any = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_any = pend_any | (cnt_q[r] != '0);
    end
  end

  // Read ports: independent combinational lookups into storage and counters.
  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REG_FILE_SB_BYPASS_EN
    logic hit;
    assign hit = we && (wr_addr == ra);
    assign rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : mem_q[ra];
    // The last outstanding write completing this cycle releases the hazard.
    assign rd_busy[i] = (cnt_q[ra] != '0) && !(hit && (cnt_q[ra] == CNT_ONE));
`else
    assign rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
    assign rd_busy[i] = (cnt_q[ra] != '0);
`endif
  end

  // State registers; reset discards storage, claims and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      wr_err_q <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic,
// checked every cycle against an array-based reference model.
module tb_reg_file_sb;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int NP = 2;
  localparam int PW = 2;
  localparam int MAXC = (1 << PW) - 1;
`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             claim_vld;
  logic [AW-1:0]    claim_addr;
  logic             claim_rdy;
  logic             flush;
  logic             pend_any;
  logic             wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NR];
  int            m_cnt [NR];
  bit            m_err;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NP), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .claim_vld(claim_vld),
    .claim_addr(claim_addr), .claim_rdy(claim_rdy), .flush(flush),
    .pend_any(pend_any), .wr_err(wr_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  // Clock-edge rules: flush clears counters; otherwise claims and completing
  // writes add and subtract from the pre-edge counts.
  task automatic model_edge();
    int nc [NR];
    for (int r = 0; r < NR; r++) nc[r] = m_cnt[r];
    if (flush) begin
      for (int r = 0; r < NR; r++) nc[r] = 0;
    end else begin
      if (claim_vld && m_cnt[claim_addr] < MAXC) nc[claim_addr] = nc[claim_addr] + 1;
      if (we && m_cnt[wr_addr] > 0) nc[wr_addr] = nc[wr_addr] - 1;
      if (we && m_cnt[wr_addr] == 0) m_err = 1'b1;
    end
    if (we) m_mem[wr_addr] = wr_data;
    for (int r = 0; r < NR; r++) m_cnt[r] = nc[r];
  endtask

  task automatic check_outputs(input string tag);
    logic [NP*DW-1:0] ed;
    logic [NP-1:0]    eb;
    bit               ep;
    for (int i = 0; i < NP; i++) begin
      int ra;
      bit hit;
      ra  = int'(rd_addr[i*AW +: AW]);
      hit = we && (int'(wr_addr) == ra);
      ed[i*DW +: DW] = (BYP && hit) ? wr_data : m_mem[ra];
      eb[i] = (m_cnt[ra] != 0) && !(BYP && hit && m_cnt[ra] == 1);
    end
    ep = 1'b0;
    for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) ep = 1'b1;
    check({tag, ".rd_data"},   64'(rd_data),   64'(ed));
    check({tag, ".rd_busy"},   64'(rd_busy),   64'(eb));
    check({tag, ".claim_rdy"}, 64'(claim_rdy), 64'(m_cnt[claim_addr] != MAXC));
    check({tag, ".pend_any"},  64'(pend_any),  64'(ep));
    check({tag, ".wr_err"},    64'(wr_err),    64'(m_err));
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; claim_vld = 1'b0; flush = 1'b0;
  endtask

  task automatic claim(input int a);
    idle(); claim_vld = 1'b1; claim_addr = AW'(a);
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    idle(); we = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".rd_data"},   64'(rd_data),   64'h0);
    check({tag, ".rd_busy"},   64'(rd_busy),   64'h0);
    check({tag, ".claim_rdy"}, 64'(claim_rdy), 64'h1);
    check({tag, ".pend_any"},  64'(pend_any),  64'h0);
    check({tag, ".wr_err"},    64'(wr_err),    64'h0);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Claim then write R3
    rd_addr = {AW'(3), AW'(3)};
    claim(3);           cycle("t2_claim");
    idle();             cycle("t2_wait0");
    check("t2_busy", 64'(rd_busy), 64'h3);
    idle();             cycle("t2_wait1");
    write(3, 16'hBEEF); cycle("t2_write");
    idle(); #1;
    check("t2_data", 64'(rd_data[DW-1:0]), 64'hBEEF);
    check("t2_pend", 64'(pend_any), 64'h0);
    cycle("t2_after");

    // Saturate R5
    rd_addr = {AW'(0), AW'(5)};
    for (int k = 0; k < 3; k++) begin claim(5); cycle("t3_claim"); end
    idle(); claim_addr = AW'(5); #1;
    check("t3_sat_rdy", 64'(claim_rdy), 64'h0);
    claim(5);           cycle("t3_claim4");
    write(5, 16'h0505); claim_vld = 1'b1; claim_addr = AW'(5); cycle("t3_wr_claim");
    idle(); claim_addr = AW'(5); #1;
    check("t3_rdy_after", 64'(claim_rdy), 64'h1);
    write(5, 16'h0506); cycle("t3_wr1");
    write(5, 16'h0507); cycle("t3_wr2");
    idle(); #1;
    check("t3_busy_clr", 64'(rd_busy[0]), 64'h0);
    cycle("t3_idle");

    // Flush with concurrent write and claim
    claim(1); cycle("t4_c1");
    claim(2); cycle("t4_c2");
    claim(7); cycle("t4_c7");
    write(2, 16'h1234); claim_vld = 1'b1; claim_addr = AW'(4); flush = 1'b1;
    cycle("t4_flush");
    idle(); rd_addr = {AW'(4), AW'(2)}; #1;
    check("t4_pend",  64'(pend_any), 64'h0);
    check("t4_r2",    64'(rd_data[DW-1:0]), 64'h1234);
    check("t4_busy",  64'(rd_busy), 64'h0);
    check("t4_err",   64'(wr_err), 64'h0);
    cycle("t4_idle");

    // Bypass behaviour on a same-cycle write/read of R4
    rd_addr = {AW'(0), AW'(4)};
    write(4, 16'hA5A5); #1;
    check("t6_same", 64'(rd_data[DW-1:0]), BYP ? 64'hA5A5 : 64'(m_mem[4]));
    cycle("t6_write");
    idle(); #1;
    check("t6_next", 64'(rd_data[DW-1:0]), 64'hA5A5);

    // Spurious write sets the sticky error
    rd_addr = {AW'(6), AW'(6)};
    write(6, 16'h00FF); cycle("t5_write");
    idle(); #1;
    check("t5_data", 64'(rd_data[DW-1:0]), 64'h00FF);
    check("t5_err",  64'(wr_err), 64'h1);
    repeat (3) cycle("t5_hold");
    check("t5_err_hold", 64'(wr_err), 64'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      rd_addr    = AW'($urandom_range(0, NR-1)) | ((NP*AW)'($urandom_range(0, NR-1)) << AW);
      claim_vld  = ($urandom_range(0, 2) != 0);
      claim_addr = AW'($urandom_range(0, NR-1));
      we         = ($urandom_range(0, 1) != 0);
      wr_addr    = AW'($urandom_range(0, NR-1));
      wr_data    = DW'($urandom);
      flush      = ($urandom_range(0, 24) == 0);
      cycle("rnd");
    end

    // Asynchronous reset mid-run
    claim(0); we = 1'b1; wr_addr = AW'(1); wr_data = 16'h7777;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    idle(); rd_addr = {AW'(1), AW'(0)};
    #1;
    reset_checks("t1_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("t1_release");
    cycle("t1_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the pipelined core, generalising the 8x16 single-write file: configurable width, depth and read-port count.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards.
- Reads are asynchronous; writes, scoreboard updates and the error flag are synchronous.
- Decode drives the read and claim ports, writeback drives the write port, and the branch unit drives flush.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers; must be a power of two and at least 2
- ADDR_W, 3, register address width; must equal log2(NUM_REGS)
- NUM_RD, 2, number of independent read ports
- PEND_W, 2, width of each per-register pending-write counter; the maximum count is 2^PEND_W-1

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  high when the addressed register has a write outstanding
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_vld  in  1  decode reserves a future write to claim_addr
- claim_addr  in  ADDR_W  register being reserved
- claim_rdy  out  1  high when claim_addr's counter is below maximum
- flush  in  1  clears all pending counters (mispredict)
- pend_any  out  1  high when any counter is non-zero
- wr_err  out  1  sticky flag: a write arrived for a register with no pending claim

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values while rst_n=0 and after release:
  - all registers = 0, so every rd_data = 0
  - all counters = 0, so rd_busy = 0 and pend_any = 0
  - claim_rdy = 1 and wr_err = 0
- Reset asserted mid-operation discards in-flight writes and claims immediately.
- Read path: rd_data[i] = storage[rd_addr[i]] combinationally, with zero latency. Ports are independent, and any ports may address the same register.
- Write: when we=1 at a rising edge, storage[wr_addr] <= wr_data. The new value is visible on rd_data the next cycle (no bypass unless BYPASS_EN is defined).
- Counter update per register r, each edge:
  - inc = claim_vld & claim_rdy & (claim_addr==r)
  - dec = we & (wr_addr==r) & (cnt[r]!=0)
  - inc & ~dec: cnt+1
  - dec & ~inc: cnt-1
  - both: unchanged
  - neither: unchanged
- claim_rdy = (cnt[claim_addr] != max), evaluated combinationally.
  - A claim with claim_rdy=0 is ignored and the counter holds.
  - Decode must stall on claim_rdy=0.
- A write to a register with cnt=0:
  - the data is still written
  - the counter stays 0 (no underflow)
  - wr_err is set to 1 and holds until reset
- flush=1 at an edge:
  - all counters go to 0
  - a claim in the same cycle is dropped
  - a write in the same cycle still updates storage
  - that write does not set wr_err
- rd_busy[i] = (cnt[rd_addr[i]] != 0), taken from registered state only.
- pend_any = OR over all counters != 0.
- Simultaneous write and claim to the same register with cnt=max: claim_rdy=0, so only the decrement applies.

Optional Feature:
Macro: REG_FILE_SB_BYPASS_EN
- Defined:
  - Write-through forwarding: when we=1 and wr_addr==rd_addr[i], rd_data[i]=wr_data in the same cycle.
  - If in addition cnt[rd_addr[i]]==1, then rd_busy[i]=0 that cycle, because the last outstanding write is completing.
- Not defined:
  - rd_data always comes from storage, so the write is visible next cycle.
  - rd_busy ignores the concurrent write.

Test Plan:
1. Reset then read: rst_n=0 mid-run, then release. All rd_data=0x0000, rd_busy=0, claim_rdy=1, pend_any=0, wr_err=0.
2. Claim and write: claim R3, wait 2 cycles, then write R3=0xBEEF.
   - rd_busy for R3 is 1 from the cycle after the claim until the cycle after the write.
   - rd_data=0xBEEF the cycle after the write; pend_any returns to 0.
3. Saturation with PEND_W=2: claim R5 three times, so cnt=3 and claim_rdy=0.
   - A 4th claim is ignored.
   - A write plus a claim to R5 in the same cycle gives cnt=2.
   - Three writes then clear busy.
4. Flush: claim R1, R2 and R7, then assert flush together with a write R2=0x1234 and a claim of R4.
   - All busy=0 and pend_any=0.
   - R2 reads 0x1234; R4 is not busy; wr_err=0.
5. Spurious write: write R6=0x00FF with no claim. R6 reads 0x00FF, wr_err=1 and stays 1 until rst_n=0.
6. Bypass: write R4=0xA5A5 with rd_addr[0]=4 in the same cycle.
   - With REG_FILE_SB_BYPASS_EN defined: rd_data[0]=0xA5A5 that cycle.
   - Without it: the old value that cycle, then 0xA5A5 next cycle.
